// File: rtl/bram2_addr_seq_l9.sv
// Layer-9 BRAM2 address-generator sequencer: one control tuple per beat,
// stall-aware, with a one-cycle done pulse after the final accepted beat.
module bram2_addr_seq_l9 #(
  parameter int TILE_DIM = 8,
  parameter int J_MAX    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] mode,
  input  logic       stall,
  output logic [2:0] u,
  output logic [1:0] L,
  output logic [1:0] j,
  output logic [2:0] z,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [3:0] x_Reg5,
  output logic [3:0] y_Reg5,
  output logic       addr_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [2:0] XY_LAST = 3'(TILE_DIM - 1);
  localparam logic [1:0] J_LAST  = 2'(J_MAX - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] mode_q, mode_d;
  logic [1:0] l_q, l_d;
  logic [1:0] jc_q, jc_d;
  logic [2:0] xc_q, xc_d;
  logic [2:0] yc_q, yc_d;
  logic [2:0] zc_q, zc_d;

  logic m2, m4, m5, m0, mz;
  logic [2:0] z_end;
  logic [1:0] j_end;
  logic [1:0] l_end;
  logic z_wrap, y_wrap, x_wrap, j_wrap;
  logic last, accept;

  assign m2 = (mode_q == 3'd2);
  assign m4 = (mode_q == 3'd4);
  assign m5 = (mode_q == 3'd5);
  assign m0 = (mode_q == 3'd0);
  assign mz = !(m2 || m4);

  // Unused loop levels get a terminal of 0 so they are always "done".
  assign z_end = (m5 || m0) ? 3'd7 : (mz ? 3'd3 : 3'd0);
  assign j_end = m4 ? J_LAST : 2'd0;
  assign l_end = (m2 || m4) ? 2'd3 : 2'd0;

  assign z_wrap = (zc_q == z_end);
  assign y_wrap = z_wrap && (yc_q == XY_LAST);
  assign x_wrap = y_wrap && (xc_q == XY_LAST);
  assign j_wrap = x_wrap && (jc_q == j_end);
  assign last   = j_wrap && (l_q == l_end);

  assign accept = (state_q == S_RUN) && !stall;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    l_d     = l_q;
    jc_d    = jc_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    zc_d    = zc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          mode_d  = mode;
          l_d     = '0;
          jc_d    = '0;
          xc_d    = '0;
          yc_d    = '0;
          zc_d    = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (last) begin
            state_d = S_FIN;
            l_d     = '0;
            jc_d    = '0;
            xc_d    = '0;
            yc_d    = '0;
            zc_d    = '0;
          end else begin
            zc_d = z_wrap ? '0 : zc_q + 3'd1;
            if (z_wrap)
              yc_d = (yc_q == XY_LAST) ? '0 : yc_q + 3'd1;
            if (y_wrap)
              xc_d = (xc_q == XY_LAST) ? '0 : xc_q + 3'd1;
            if (x_wrap)
              jc_d = (jc_q == j_end) ? '0 : jc_q + 2'd1;
            if (j_wrap)
              l_d = l_q + 2'd1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      l_q     <= '0;
      jc_q    <= '0;
      xc_q    <= '0;
      yc_q    <= '0;
      zc_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      l_q     <= l_d;
      jc_q    <= jc_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      zc_q    <= zc_d;
    end
  end

  // Tuple decode is gated by RUN so reset clears every output at once.
  always_comb begin
    u      = '0;
    L      = '0;
    j      = '0;
    z      = '0;
    x      = '0;
    y      = '0;
    x_Reg5 = '0;
    y_Reg5 = '0;
    if (state_q == S_RUN) begin
      unique case (1'b1)
        m2: begin
          u = 3'd2;
          L = l_q;
          x = {1'b0, xc_q};
          y = {1'b0, yc_q};
        end
        m4: begin
          u = 3'd4;
          L = l_q;
          j = jc_q + 2'd1;
          x = {1'b0, xc_q};
          y = {1'b0, yc_q};
        end
        m5: begin
          u      = 3'd5;
          z      = zc_q + 3'd2;
          x_Reg5 = {1'b0, xc_q};
          y_Reg5 = {1'b0, yc_q};
        end
        m0: begin
          u      = {2'b00, zc_q[2] & zc_q[1]};
          z      = zc_q + 3'd2;
          x_Reg5 = {xc_q, 1'b0};
          y_Reg5 = {yc_q, 1'b0};
        end
        default: begin
          u      = mode_q;
          z      = {1'b0, zc_q[1:0] + 2'd1};
          x_Reg5 = {1'b0, xc_q};
          y_Reg5 = {1'b0, yc_q};
        end
      endcase
    end
  end

  assign addr_valid = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN) || (state_q == S_FIN);
  assign done       = (state_q == S_FIN);

endmodule

// File: tb/tb_bram2_addr_seq_l9.sv
// Directed bench for bram2_addr_seq_l9 with a queue scoreboard of tuples.
module tb_bram2_addr_seq_l9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       stall = 1'b0;
  logic [2:0] u;
  logic [1:0] L;
  logic [1:0] j;
  logic [2:0] z;
  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] x_Reg5;
  logic [3:0] y_Reg5;
  logic       addr_valid;
  logic       busy;
  logic       done;

  bram2_addr_seq_l9 dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stall(stall),
    .u(u), .L(L), .j(j), .z(z), .x(x), .y(y),
    .x_Reg5(x_Reg5), .y_Reg5(y_Reg5),
    .addr_valid(addr_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [25:0] obs;
  assign obs = {u, L, j, z, x, y, x_Reg5, y_Reg5};

  logic [25:0] q[$];
  logic [25:0] got[1024];
  int n_chk = 0;
  int n_fail = 0;
  int zero_j = 0;

  function automatic logic [25:0] tup(input int u_, input int l_,
    input int j_, input int z_, input int x_, input int y_,
    input int xr_, input int yr_);
    return {3'(u_), 2'(l_), 2'(j_), 3'(z_), 4'(x_), 4'(y_),
            4'(xr_), 4'(yr_)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
    input logic [31:0] e);
    n_chk++;
    assert (o === e)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic build(input int m);
    int zo5[8] = '{2, 3, 4, 5, 6, 7, 0, 1};
    int zog[4] = '{1, 2, 3, 0};
    q.delete();
    if (m == 2) begin
      for (int l = 0; l < 4; l++)
        for (int xi = 0; xi < 8; xi++)
          for (int yi = 0; yi < 8; yi++)
            q.push_back(tup(2, l, 0, 0, xi, yi, 0, 0));
    end else if (m == 4) begin
      for (int l = 0; l < 4; l++)
        for (int jj = 1; jj <= 3; jj++)
          for (int xi = 0; xi < 8; xi++)
            for (int yi = 0; yi < 8; yi++)
              q.push_back(tup(4, l, jj, 0, xi, yi, 0, 0));
    end else if (m == 5) begin
      for (int xi = 0; xi < 8; xi++)
        for (int yi = 0; yi < 8; yi++)
          for (int k = 0; k < 8; k++)
            q.push_back(tup(5, 0, 0, zo5[k], 0, 0, xi, yi));
    end else if (m == 0) begin
      for (int xi = 0; xi < 16; xi += 2)
        for (int yi = 0; yi < 16; yi += 2)
          for (int k = 0; k < 8; k++)
            q.push_back(tup(k >= 6 ? 1 : 0, 0, 0, zo5[k], 0, 0, xi, yi));
    end else begin
      for (int xi = 0; xi < 8; xi++)
        for (int yi = 0; yi < 8; yi++)
          for (int k = 0; k < 4; k++)
            q.push_back(tup(m, 0, 0, zog[k], 0, 0, xi, yi));
    end
  endtask

  task automatic run(input int m, input int sa, input int sb,
    input int slen, input int abort_at, input int poke_at,
    output int beats, output int done_cyc, output int ndone);
    int cyc;
    int hold;
    bit poked;
    bit s;
    beats = 0;
    done_cyc = -1;
    ndone = 0;
    hold = 0;
    poked = 0;
    zero_j = 0;
    build(m);
    @(negedge clk);
    mode = 3'(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 2000) begin
      start = 1'b0;
      mode = 3'(m);
      if (abort_at >= 0 && beats == abort_at && addr_valid) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_outputs", 32'({obs, addr_valid, busy, done}), 32'd0);
        repeat (3) begin
          @(negedge clk);
          chk("rst_no_done", 32'({done, addr_valid, busy}), 32'd0);
        end
        rst = 1'b0;
        stall = 1'b0;
        q.delete();
        return;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
        chk("fin_valid", 32'(addr_valid), 32'd0);
        chk("fin_busy", 32'(busy), 32'd1);
      end else if (done_cyc >= 0) begin
        chk("idle_busy", 32'(busy), 32'd0);
        break;
      end
      if (poke_at >= 0 && beats == poke_at && !poked) begin
        start = 1'b1;
        mode = 3'd2;
        poked = 1;
      end
      if (addr_valid) begin
        chk("q_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() == 0) break;
        chk("beat", 32'(obs), 32'(q[0]));
        if (m == 4 && j == 2'd0) zero_j++;
        s = ((beats == sa) || (beats == sb)) && (hold < slen);
        stall = s;
        if (s) hold++;
        else begin
          got[beats] = obs;
          void'(q.pop_front());
          beats++;
          hold = 0;
        end
      end else begin
        stall = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    stall = 1'b0;
    chk("run_terminated", 32'(done_cyc >= 0), 32'd1);
  endtask

  initial begin
    int b, dc, nd;
    int pu[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    int pz[8] = '{2, 3, 4, 5, 6, 7, 0, 1};
    #12;
    chk("reset_state", 32'({obs, addr_valid, busy, done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(2, -1, -1, 0, -1, -1, b, dc, nd);
    chk("m2_beats", 32'(b), 32'd256);
    chk("m2_done_cyc", 32'(dc), 32'd257);
    chk("m2_ndone", 32'(nd), 32'd1);
    chk("m2_b0", 32'(got[0]), 32'(tup(2, 0, 0, 0, 0, 0, 0, 0)));
    chk("m2_b8", 32'(got[8]), 32'(tup(2, 0, 0, 0, 1, 0, 0, 0)));
    chk("m2_b64", 32'(got[64]), 32'(tup(2, 1, 0, 0, 0, 0, 0, 0)));
    chk("m2_last", 32'(got[255]), 32'(tup(2, 3, 0, 0, 7, 7, 0, 0)));

    run(4, -1, -1, 0, -1, -1, b, dc, nd);
    chk("m4_beats", 32'(b), 32'd768);
    chk("m4_ndone", 32'(nd), 32'd1);
    chk("m4_zero_j", 32'(zero_j), 32'd0);
    chk("m4_b0", 32'(got[0]), 32'(tup(4, 0, 1, 0, 0, 0, 0, 0)));
    chk("m4_b64", 32'(got[64]), 32'(tup(4, 0, 2, 0, 0, 0, 0, 0)));
    chk("m4_b192", 32'(got[192]), 32'(tup(4, 1, 1, 0, 0, 0, 0, 0)));

    run(0, -1, -1, 0, -1, -1, b, dc, nd);
    chk("m0_beats", 32'(b), 32'd512);
    chk("m0_done_cyc", 32'(dc), 32'd513);
    for (int k = 0; k < 8; k++)
      chk("m0_pair", 32'(got[k]), 32'(tup(pu[k], 0, 0, pz[k], 0, 0, 0, 0)));
    chk("m0_b8", 32'(got[8]), 32'(tup(0, 0, 0, 2, 0, 0, 0, 2)));
    chk("m0_last", 32'(got[511]), 32'(tup(1, 0, 0, 1, 0, 0, 14, 14)));

    run(5, 3, 511, 4, -1, -1, b, dc, nd);
    chk("m5_beats", 32'(b), 32'd512);
    chk("m5_done_cyc", 32'(dc), 32'd521);
    chk("m5_ndone", 32'(nd), 32'd1);
    chk("m5_last", 32'(got[511]), 32'(tup(5, 0, 0, 1, 0, 0, 7, 7)));

    run(4, -1, -1, 0, 100, -1, b, dc, nd);
    run(2, -1, -1, 0, -1, -1, b, dc, nd);
    chk("rr_beats", 32'(b), 32'd256);
    chk("rr_done_cyc", 32'(dc), 32'd257);
    chk("rr_ndone", 32'(nd), 32'd1);

    run(7, -1, -1, 0, -1, 50, b, dc, nd);
    chk("m7_beats", 32'(b), 32'd256);
    chk("m7_ndone", 32'(nd), 32'd1);
    chk("m7_b0", 32'(got[0]), 32'(tup(7, 0, 0, 1, 0, 0, 0, 0)));
    chk("m7_b3", 32'(got[3]), 32'(tup(7, 0, 0, 0, 0, 0, 0, 0)));
    chk("m7_last", 32'(got[255]), 32'(tup(7, 0, 0, 0, 0, 0, 7, 7)));
    repeat (3) @(negedge clk);
    chk("idle_quiet", 32'({busy, addr_valid, done}), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
